// File: rtl/sam_sram_pkg.sv
// Shared types and defaults for the SAM Coupe SRAM configuration arbiter.
// CFG_WRITEBACK_EN adds the write-back states to the FSM encoding.
package sam_sram_pkg;

    localparam int                 SRAM_AW         = 21;
    localparam logic [SRAM_AW-1:0] CFG_BASE_DEF    = 21'h008FD5;
    localparam int                 CFG_BYTES_DEF   = 2;
    localparam int                 WAIT_CYCLES_DEF = 3;

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_RUN      = 3'd2
`ifdef CFG_WRITEBACK_EN
        ,
        ST_WB_SETUP = 3'd3,
        ST_WB_PULSE = 3'd4,
        ST_WB_HOLD  = 3'd5
`endif
    } state_e;

    // Address of config byte idx; wraps within the 21-bit SRAM space.
    function automatic logic [SRAM_AW-1:0] cfg_addr(input logic [SRAM_AW-1:0] base,
                                                    input logic [1:0]         idx);
        return base + {{(SRAM_AW-2){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/sram_cfg_regfile.sv
// Configuration byte bank: one write port shared by boot load and write-back,
// flat read-out with byte i at [8i+7:8i].
module sram_cfg_regfile #(
    parameter int BYTES = 2
) (
    input  logic               clk24,
    input  logic               reset,
    input  logic               we,
    input  logic [1:0]         idx,
    input  logic [7:0]         wdata,
    output logic [8*BYTES-1:0] cfg
);

    logic [8*BYTES-1:0] cfg_r;

    // Byte write; indices outside the bank are silently dropped.
    always_ff @(posedge clk24) begin
        if (reset) begin
            cfg_r <= {(8*BYTES){1'b0}};
        end else if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (idx == b[1:0]) begin
                    cfg_r[8*b +: 8] <= wdata;
                end
            end
        end
    end

    assign cfg = cfg_r;

endmodule

// File: rtl/sram_cfg_arbiter.sv
// SRAM bus owner: boot-loads config bytes, holds the core in reset until done,
// then passes core traffic through. CFG_WRITEBACK_EN enables config write-back.
module sram_cfg_arbiter
    import sam_sram_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] CFG_BASE    = CFG_BASE_DEF,
    parameter int                 CFG_BYTES   = CFG_BYTES_DEF,
    parameter int                 WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                   clk24,
    input  logic                   reset,
    input  logic [18:0]            core_addr,
    input  logic                   core_we_n,
    input  logic                   core_slot_free,
    input  logic [7:0]             sram_din,
    input  logic                   wb_req,
    input  logic [1:0]             wb_index,
    input  logic [7:0]             wb_data,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic                   sram_we_n,
    output logic [7:0]             sram_dout,
    output logic                   sram_doe,
    output logic [8*CFG_BYTES-1:0] cfg,
    output logic                   cfg_valid,
    output logic                   core_reset_n,
    output logic                   wb_ack
);

    localparam logic [1:0] LAST_IDX  = 2'(CFG_BYTES - 1);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_e             state_r;
    logic [1:0]         byte_idx_r;
    logic [3:0]         wait_cnt_r;
    logic [SRAM_AW-1:0] addr_r;
    logic               we_n_r;
    logic               cfg_valid_r;
    logic               core_reset_n_r;
    logic               rf_we_s;
    logic [1:0]         rf_idx_s;
    logic [7:0]         rf_wdata_s;

`ifdef CFG_WRITEBACK_EN
    logic               doe_r;
    logic               wb_ack_r;
    logic [7:0]         dout_r;
    logic [1:0]         wb_idx_r;
    logic               wb_grant_s;
    logic               wb_in_range_s;

    assign wb_in_range_s = ({1'b0, wb_index} < 3'(CFG_BYTES));
    // The ack cycle blocks a second grant while the requester drops wb_req.
    assign wb_grant_s    = wb_req && core_slot_free && !wb_ack_r;
`endif

    // Boot loader, run-mode hand-over and write-back sequencer.
    always_ff @(posedge clk24) begin
        if (reset) begin
            state_r        <= ST_LOAD;
            byte_idx_r     <= 2'd0;
            wait_cnt_r     <= 4'd0;
            addr_r         <= CFG_BASE;
            we_n_r         <= 1'b1;
            cfg_valid_r    <= 1'b0;
            core_reset_n_r <= 1'b0;
`ifdef CFG_WRITEBACK_EN
            doe_r          <= 1'b0;
            wb_ack_r       <= 1'b0;
            dout_r         <= 8'h00;
            wb_idx_r       <= 2'd0;
`endif
        end else begin
`ifdef CFG_WRITEBACK_EN
            wb_ack_r <= 1'b0;
`endif
            case (state_r)
                ST_LOAD: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_r <= 4'd0;
                        state_r    <= ST_LATCH;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                ST_LATCH: begin
                    if (byte_idx_r == LAST_IDX) begin
                        state_r        <= ST_RUN;
                        cfg_valid_r    <= 1'b1;
                        core_reset_n_r <= 1'b1;
                    end else begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        addr_r     <= cfg_addr(CFG_BASE, byte_idx_r + 2'd1);
                        state_r    <= ST_LOAD;
                    end
                end
                ST_RUN: begin
`ifdef CFG_WRITEBACK_EN
                    if (wb_grant_s && wb_in_range_s) begin
                        wb_idx_r   <= wb_index;
                        dout_r     <= wb_data;
                        addr_r     <= cfg_addr(CFG_BASE, wb_index);
                        doe_r      <= 1'b1;
                        we_n_r     <= 1'b1;
                        wait_cnt_r <= 4'd0;
                        state_r    <= ST_WB_SETUP;
                    end else if (wb_grant_s) begin
                        wb_ack_r <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
`else
                    state_r <= ST_RUN;
`endif
                end
`ifdef CFG_WRITEBACK_EN
                ST_WB_SETUP: begin
                    we_n_r     <= 1'b0;
                    wait_cnt_r <= 4'd0;
                    state_r    <= ST_WB_PULSE;
                end
                ST_WB_PULSE: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        we_n_r     <= 1'b1;
                        wb_ack_r   <= 1'b1;
                        wait_cnt_r <= 4'd0;
                        state_r    <= ST_WB_HOLD;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                ST_WB_HOLD: begin
                    doe_r   <= 1'b0;
                    state_r <= ST_RUN;
                end
`endif
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    // Register bank write port: boot latch or write-back commit on leaving HOLD.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_idx_s   = byte_idx_r;
        rf_wdata_s = sram_din;
        if (state_r == ST_LATCH) begin
            rf_we_s = 1'b1;
        end
`ifdef CFG_WRITEBACK_EN
        else if (state_r == ST_WB_HOLD) begin
            rf_we_s    = 1'b1;
            rf_idx_s   = wb_idx_r;
            rf_wdata_s = dout_r;
        end
`endif
        else begin
            rf_we_s = 1'b0;
        end
    end

    sram_cfg_regfile #(
        .BYTES (CFG_BYTES)
    ) u_regfile (
        .clk24 (clk24),
        .reset (reset),
        .we    (rf_we_s),
        .idx   (rf_idx_s),
        .wdata (rf_wdata_s),
        .cfg   (cfg)
    );

    // Core traffic bypasses all registers so the core sees zero added latency.
    assign sram_addr    = (state_r == ST_RUN) ? {2'b00, core_addr} : addr_r;
    assign sram_we_n    = (state_r == ST_RUN) ? core_we_n : we_n_r;
    assign cfg_valid    = cfg_valid_r;
    assign core_reset_n = core_reset_n_r;

`ifdef CFG_WRITEBACK_EN
    assign sram_doe  = doe_r;
    assign sram_dout = dout_r;
    assign wb_ack    = wb_ack_r;
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_req, wb_index, wb_data, core_slot_free};
    assign sram_doe    = 1'b0;
    assign sram_dout   = 8'h00;
    assign wb_ack      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_cfg_arbiter.sv
// Self-checking bench for sram_cfg_arbiter with a behavioural SRAM and config model;
// write-back expectations follow CFG_WRITEBACK_EN.
module tb_sram_cfg_arbiter;

    localparam logic [20:0] BASE = 21'h008FD5;
    localparam int          NB   = 2;
    localparam int          WC   = 3;
    localparam int          BOOT = NB * (WC + 1);
`ifdef CFG_WRITEBACK_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    logic            clk24 = 1'b0;
    logic            reset;
    logic [18:0]     core_addr;
    logic            core_we_n;
    logic            core_slot_free;
    logic [7:0]      sram_din;
    logic            wb_req;
    logic [1:0]      wb_index;
    logic [7:0]      wb_data;
    logic [20:0]     sram_addr;
    logic            sram_we_n;
    logic [7:0]      sram_dout;
    logic            sram_doe;
    logic [8*NB-1:0] cfg;
    logic            cfg_valid;
    logic            core_reset_n;
    logic            wb_ack;

    logic [7:0]      mem [0:3];
    logic [8*NB-1:0] exp_cfg;
    logic [20:0]     rd_off;
    int              errors = 0;
    int              checks = 0;

    sram_cfg_arbiter #(
        .CFG_BASE    (BASE),
        .CFG_BYTES   (NB),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk24          (clk24),
        .reset          (reset),
        .core_addr      (core_addr),
        .core_we_n      (core_we_n),
        .core_slot_free (core_slot_free),
        .sram_din       (sram_din),
        .wb_req         (wb_req),
        .wb_index       (wb_index),
        .wb_data        (wb_data),
        .sram_addr      (sram_addr),
        .sram_we_n      (sram_we_n),
        .sram_dout      (sram_dout),
        .sram_doe       (sram_doe),
        .cfg            (cfg),
        .cfg_valid      (cfg_valid),
        .core_reset_n   (core_reset_n),
        .wb_ack         (wb_ack)
    );

    always #5 clk24 = ~clk24;

    // Asynchronous SRAM read: config window backed by mem, elsewhere an address pattern.
    always_comb begin
        rd_off = sram_addr - BASE;
        if (rd_off < 21'd4) sram_din = mem[rd_off[1:0]];
        else                sram_din = sram_addr[7:0] ^ 8'h5C;
    end

    // Level-sensitive SRAM write of arbiter-driven data, sampled once per cycle.
    task automatic sram_capture();
        logic [20:0] off;
        off = sram_addr - BASE;
        if (sram_we_n === 1'b0 && sram_doe === 1'b1 && off < 21'd4) mem[off[1:0]] = sram_dout;
    endtask

    task automatic boot();
        logic        exp_v;
        logic [20:0] exp_addr;
        reset = 1'b1;
        @(negedge clk24);
        sram_capture();
        checks++;
        if ({sram_addr, sram_we_n, sram_doe, sram_dout, cfg_valid, core_reset_n, wb_ack} !==
            {BASE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got addr=%h we_n=%b doe=%b dout=%h valid=%b crn=%b ack=%b required addr=%h we_n=1 doe=0 dout=00 valid=0 crn=0 ack=0",
                     sram_addr, sram_we_n, sram_doe, sram_dout, cfg_valid, core_reset_n, wb_ack, BASE);
        end
        checks++;
        if (cfg !== {(8*NB){1'b0}}) begin
            errors++;
            $display("FAIL reset_cfg: got %h required 0", cfg);
        end
        for (int b = 0; b < NB; b++) exp_cfg[8*b +: 8] = mem[b];
        reset = 1'b0;
        for (int k = 0; k <= BOOT + 1; k++) begin
            exp_v = (k >= BOOT);
            checks++;
            if (cfg_valid !== exp_v || core_reset_n !== exp_v) begin
                errors++;
                $display("FAIL boot_release k=%0d: got valid=%b crn=%b required %b", k, cfg_valid, core_reset_n, exp_v);
            end
            checks++;
            if (sram_we_n !== 1'b1 || sram_doe !== 1'b0) begin
                errors++;
                $display("FAIL boot_no_write k=%0d: got we_n=%b doe=%b required we_n=1 doe=0", k, sram_we_n, sram_doe);
            end
            if (k < BOOT) begin
                exp_addr = BASE + 21'(k / (WC + 1));
                checks++;
                if (sram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL boot_addr k=%0d: got %h required %h", k, sram_addr, exp_addr);
                end
            end
            @(negedge clk24);
            sram_capture();
        end
        checks++;
        if (cfg !== exp_cfg) begin
            errors++;
            $display("FAIL boot_cfg: got %h required %h", cfg, exp_cfg);
        end
    endtask

    task automatic do_wb(input logic [1:0] idx, input logic [7:0] data);
        logic            in_rng;
        logic            exp_ack;
        logic            exp_doe;
        logic            exp_we;
        logic [20:0]     exp_addr;
        logic [8*NB-1:0] old_cfg;
        logic [8*NB-1:0] new_cfg;
        in_rng   = WB_ON && (int'(idx) < NB);
        old_cfg  = exp_cfg;
        new_cfg  = exp_cfg;
        if (in_rng) new_cfg[8*int'(idx) +: 8] = data;
        exp_addr = BASE + {19'd0, idx};
        wb_req = 1'b1; wb_index = idx; wb_data = data; core_slot_free = 1'b1; core_we_n = 1'b1;
        for (int c = 1; c <= WC + 3; c++) begin
            @(negedge clk24);
            sram_capture();
            exp_ack = WB_ON && (in_rng ? (c == WC + 2) : (c == 1));
            exp_doe = in_rng && (c <= WC + 2);
            exp_we  = !(in_rng && c >= 2 && c <= WC + 1);
            checks++;
            if (wb_ack !== exp_ack) begin
                errors++;
                $display("FAIL wb_ack idx=%0d c=%0d: got %b required %b", idx, c, wb_ack, exp_ack);
            end
            checks++;
            if (sram_doe !== exp_doe || sram_we_n !== exp_we) begin
                errors++;
                $display("FAIL wb_strobes idx=%0d c=%0d: got doe=%b we_n=%b required doe=%b we_n=%b",
                         idx, c, sram_doe, sram_we_n, exp_doe, exp_we);
            end
            if (exp_doe) begin
                checks++;
                if (sram_addr !== exp_addr || sram_dout !== data) begin
                    errors++;
                    $display("FAIL wb_bus idx=%0d c=%0d: got addr=%h dout=%h required addr=%h dout=%h",
                             idx, c, sram_addr, sram_dout, exp_addr, data);
                end
            end
            checks++;
            if (cfg !== ((c == WC + 3) ? new_cfg : old_cfg)) begin
                errors++;
                $display("FAIL wb_cfg idx=%0d c=%0d: got %h required %h", idx, c, cfg,
                         (c == WC + 3) ? new_cfg : old_cfg);
            end
            if (exp_ack) begin
                wb_req = 1'b0; core_slot_free = 1'b0;
            end
        end
        wb_req = 1'b0; core_slot_free = 1'b0;
        exp_cfg = new_cfg;
        if (in_rng) begin
            checks++;
            if (mem[idx] !== data) begin
                errors++;
                $display("FAIL wb_sram_content idx=%0d: got %h required %h", idx, mem[idx], data);
            end
        end
    endtask

    task automatic test_reset();
        mem[0] = 8'h03; mem[1] = 8'hA5;
        boot();
        checks++;
        if (cfg !== 16'hA503) begin
            errors++;
            $display("FAIL boot_value: got %h required a503", cfg);
        end
    endtask

    task automatic test_run_passthrough();
        logic [18:0] a;
        logic        w;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 19'h12345 : 19'($urandom);
            w = (i % 2 == 0);
            core_addr = a; core_we_n = w;
            #1;
            checks++;
            if (sram_addr !== {2'b00, a} || sram_we_n !== w || sram_doe !== 1'b0) begin
                errors++;
                $display("FAIL run_pass i=%0d: got addr=%h we_n=%b doe=%b required addr=%h we_n=%b doe=0",
                         i, sram_addr, sram_we_n, sram_doe, {2'b00, a}, w);
            end
            @(negedge clk24);
        end
        core_we_n = 1'b1;
    endtask

    task automatic test_writeback();
        do_wb(2'd1, 8'h5A);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_wb(2'($urandom_range(0, 3)), 8'($urandom));
    endtask

    task automatic test_wb_out_of_range();
        do_wb(2'd3, 8'hC3);
        do_wb(2'd2, 8'h3C);
    endtask

    task automatic test_wb_pending_during_load();
        logic [7:0] d;
        d = 8'($urandom);
        mem[0] = 8'($urandom); mem[1] = 8'($urandom);
        wb_req = 1'b1; wb_index = 2'd0; wb_data = d; core_slot_free = 1'b0;
        boot();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sram_we_n !== 1'b1 || sram_doe !== 1'b0 || wb_ack !== 1'b0) begin
                errors++;
                $display("FAIL pending_no_slot i=%0d: got we_n=%b doe=%b ack=%b required 1 0 0", i, sram_we_n, sram_doe, wb_ack);
            end
            @(negedge clk24);
            sram_capture();
        end
        do_wb(2'd0, d);
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d;
        d = 8'($urandom);
        mem[1] = 8'($urandom);
        wb_req = 1'b1; wb_index = 2'd0; wb_data = d; core_slot_free = 1'b1;
        @(negedge clk24); sram_capture();
        @(negedge clk24); sram_capture();
        reset = 1'b1; wb_req = 1'b0; core_slot_free = 1'b0;
        @(negedge clk24); sram_capture();
        checks++;
        if (sram_we_n !== 1'b1 || sram_doe !== 1'b0 || core_reset_n !== 1'b0 || cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write: got we_n=%b doe=%b crn=%b valid=%b required 1 0 0 0",
                     sram_we_n, sram_doe, core_reset_n, cfg_valid);
        end
        boot();
    endtask

    initial begin
        reset = 1'b1; core_addr = 19'd0; core_we_n = 1'b1; core_slot_free = 1'b0;
        wb_req = 1'b0; wb_index = 2'd0; wb_data = 8'h00;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h77; mem[3] = 8'h88;
        exp_cfg = {(8*NB){1'b0}};
        @(negedge clk24);
        test_reset();
        test_run_passthrough();
        test_writeback();
        test_back_to_back();
        test_wb_out_of_range();
        test_wb_pending_during_load();
        test_reset_mid_write();
        test_run_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
